fpu_addsub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit half-precision add/sub unit between `NREQ` requesters. It captures a requester's operands and drives the unit's start/operand inputs. It then waits for completion, overflow or a watchdog timeout, and returns the result with the requester's ID. It sits between the FPU issue logic and the add/sub datapath.

---
 rtl/fpu_addsub_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter
//
// Round-robin arbiter and sequencer sharing one FP16 add/sub unit between NREQ requesters.
// A selected requester's operands are latched and held on unit_x_o/unit_y_o/unit_add_sub_o
// for the whole operation. unit_start_o is pulsed once, and the unit's completion, flags or an
// optional watchdog timeout are returned as a one-cycle response tagged with the requester id.
//
// Optional feature macro: FPU_ARB_TIMEOUT_EN enables a RUN-state watchdog of TIMEOUT cycles.
// When the macro is undefined, RUN waits indefinitely for done or nonzero flags.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_i          synchronous active-high reset
//   req_i            level request per requester
//   req_x_i/req_y_i  flattened FP16 operands, slice i = [16i+15:16i]
//   req_add_sub_i    per-requester operation (0 add, 1 subtract)
//   grant_o          one-hot grant pulse in the cycle the operands are handed to the unit
//   resp_valid_o     one-cycle response strobe
//   resp_id_o        served requester index
//   resp_result_o    FP16 result (0x0000 on overflow/underflow/timeout)
//   resp_ofuf_o      00 ok, 10 overflow, 01 underflow, 11 timeout
//   unit_x_o/unit_y_o/unit_add_sub_o  registered operands to the unit
//   unit_start_o     one-cycle load/start pulse to the unit
//   unit_done_i/unit_result_i/unit_ofuf_i  unit completion, result and flags
module fpu_addsub_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [16*NREQ-1:0]   req_x_i,
  input  logic [16*NREQ-1:0]   req_y_i,
  input  logic [NREQ-1:0]      req_add_sub_i,
  output logic [NREQ-1:0]      grant_o,
  output logic                 resp_valid_o,
  output logic [2:0]           resp_id_o,
  output logic [15:0]          resp_result_o,
  output logic [1:0]           resp_ofuf_o,
  output logic [15:0]          unit_x_o,
  output logic [15:0]          unit_y_o,
  output logic                 unit_add_sub_o,
  output logic                 unit_start_o,
  input  logic                 unit_done_i,
  input  logic [15:0]          unit_result_i,
  input  logic [1:0]           unit_ofuf_i
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("fpu_addsub_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  id_q, id_d;
  logic [15:0] ux_q, ux_d;
  logic [15:0] uy_q, uy_d;
  logic        uas_q, uas_d;
  logic [15:0] result_q, result_d;
  logic [1:0]  ofuf_q, ofuf_d;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // Requester index reached by stepping 'off' places past 'base', modulo NREQ.
  function automatic int unsigned wrap_idx(input logic [2:0] base, input int unsigned off);
    int unsigned t;
    t = 32'(base) + off;
    if (t >= NREQ) t = t - NREQ;
    return t;
  endfunction

  // First pending requester at or after ptr_q.
  logic       sel_found;
  logic [2:0] sel_id;

  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!sel_found && req_i[j] && (j == wrap_idx(ptr_q, off))) begin
          sel_found = 1'b1;
          sel_id    = 3'(j);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    ux_d     = ux_q;
    uy_d     = uy_q;
    uas_d    = uas_q;
    result_d = result_q;
    ofuf_d   = ofuf_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          id_d = sel_id;
          for (int unsigned j = 0; j < NREQ; j++) begin
            if (sel_id == 3'(j)) begin
              ux_d  = req_x_i[16*j +: 16];
              uy_d  = req_y_i[16*j +: 16];
              uas_d = req_add_sub_i[j];
            end
          end
          state_d = StLoad;
        end
      end
      StLoad: begin
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = StRun;
      end
      StRun: begin
        // Flags win over done: on overflow the unit's result bus is not trustworthy.
        if (unit_ofuf_i != 2'b00) begin
          ofuf_d   = unit_ofuf_i;
          result_d = 16'h0000;
          state_d  = StResp;
        end else if (unit_done_i) begin
          ofuf_d   = 2'b00;
          result_d = unit_result_i;
          state_d  = StResp;
        end else begin
`ifdef FPU_ARB_TIMEOUT_EN
          if (cnt_q == CntLast) begin
            ofuf_d   = 2'b11;
            result_d = 16'h0000;
            state_d  = StResp;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      StResp: begin
        ptr_d   = (id_q == 3'(NREQ - 1)) ? 3'd0 : id_q + 3'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      id_q     <= '0;
      ux_q     <= '0;
      uy_q     <= '0;
      uas_q    <= 1'b0;
      result_q <= '0;
      ofuf_q   <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      ux_q     <= ux_d;
      uy_q     <= uy_d;
      uas_q    <= uas_d;
      result_q <= result_d;
      ofuf_q   <= ofuf_d;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NREQ; j++) begin
      grant_o[j] = (state_q == StLoad) && (id_q == 3'(j));
    end
    unit_start_o   = (state_q == StLoad);
    resp_valid_o   = (state_q == StResp);
    resp_id_o      = id_q;
    resp_result_o  = result_q;
    resp_ofuf_o    = ofuf_q;
    unit_x_o       = ux_q;
    unit_y_o       = uy_q;
    unit_add_sub_o = uas_q;
  end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Testbench for fpu_addsub_arbiter: table-driven directed vectors, round-robin, timeout,
// mid-operation reset and randomized operations against a behavioural arbitration model.
module tb_fpu_addsub_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req;
  logic [15:0] rx[4];
  logic [15:0] ry[4];
  logic [3:0]  rs;
  logic [63:0] req_x, req_y;
  assign req_x = {rx[3], rx[2], rx[1], rx[0]};
  assign req_y = {ry[3], ry[2], ry[1], ry[0]};

  logic [3:0]  grant;
  logic        resp_valid;
  logic [2:0]  resp_id;
  logic [15:0] resp_result;
  logic [1:0]  resp_ofuf;
  logic [15:0] unit_x, unit_y;
  logic        unit_add_sub, unit_start;
  logic        unit_done;
  logic [15:0] unit_result;
  logic [1:0]  unit_ofuf;

  fpu_addsub_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_i          (req),
    .req_x_i        (req_x),
    .req_y_i        (req_y),
    .req_add_sub_i  (rs),
    .grant_o        (grant),
    .resp_valid_o   (resp_valid),
    .resp_id_o      (resp_id),
    .resp_result_o  (resp_result),
    .resp_ofuf_o    (resp_ofuf),
    .unit_x_o       (unit_x),
    .unit_y_o       (unit_y),
    .unit_add_sub_o (unit_add_sub),
    .unit_start_o   (unit_start),
    .unit_done_i    (unit_done),
    .unit_result_i  (unit_result),
    .unit_ofuf_i    (unit_ofuf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stub unit behaviour: {done_with_flags, flags, result}. Known FP16 sums are listed;
  // anything else gets an arbitrary but deterministic result.
  function automatic logic [18:0] unit_fn(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
    if (!s && x == 16'h3C00 && y == 16'h4000) return {1'b0, 2'b00, 16'h4200};
    if ( s && x == 16'h0000 && y == 16'h4000) return {1'b0, 2'b00, 16'hC000};
    if ( s && x == 16'h4000 && y == 16'h3C00) return {1'b0, 2'b00, 16'h3C00};
    if (!s && x == 16'h3C00 && y == 16'h3C00) return {1'b0, 2'b00, 16'h4000};
    if (!s && x == 16'h7800 && y == 16'h7800) return {1'b0, 2'b10, 16'hDEAD};
    if (!s && x == 16'h7BFF && y == 16'h7BFF) return {1'b1, 2'b10, 16'hBEEF};
    if ( s && x == 16'h0401 && y == 16'h0400) return {1'b0, 2'b01, 16'hDEAD};
    return {1'b0, 2'b00, x ^ {y[7:0], y[15:8]} ^ {16{s}}};
  endfunction

  // Stub unit: re-reads operands when it finishes, keeps done/flags high until next start.
  bit          stub_silent = 1'b0;
  int          stub_lat = 0;
  logic        stub_busy;
  int          stub_cnt;
  logic [18:0] fn_now;
  assign fn_now = unit_fn(unit_x, unit_y, unit_add_sub);

  always @(posedge clk) begin
    if (reset) begin
      stub_busy   <= 1'b0;
      stub_cnt    <= 0;
      unit_done   <= 1'b0;
      unit_ofuf   <= 2'b00;
      unit_result <= 16'h0000;
    end else if (unit_start) begin
      stub_busy   <= 1'b1;
      stub_cnt    <= stub_lat;
      unit_done   <= 1'b0;
      unit_ofuf   <= 2'b00;
      unit_result <= 16'hDEAD;
    end else if (stub_busy && !stub_silent) begin
      if (stub_cnt == 0) begin
        stub_busy   <= 1'b0;
        unit_ofuf   <= fn_now[17:16];
        unit_done   <= (fn_now[17:16] == 2'b00) || fn_now[18];
        unit_result <= fn_now[15:0];
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Results of the last serve() call.
  bit          s_got_grant, s_got_resp, s_stable;
  logic [3:0]  s_g, s_g_after;
  logic [15:0] s_ux, s_uy;
  logic        s_us, s_st;
  logic [2:0]  s_id;
  logic [15:0] s_res;
  logic [1:0]  s_fl;
  int          s_run;
  time         s_gtime;

  task automatic serve(input logic [3:0] mask, input int budget, input bit hold);
    s_got_grant = 1'b0;
    s_got_resp  = 1'b0;
    s_stable    = 1'b1;
    s_run       = 0;
    s_g_after   = 4'hx;
    req = mask;
    for (int w = 0; w < 12; w++) begin
      @(posedge clk); #1;
      if (grant != 4'b0000) begin
        s_got_grant = 1'b1;
        break;
      end
    end
    if (!s_got_grant) begin
      req = 4'b0000;
      return;
    end
    s_gtime = $time;
    s_g  = grant;
    s_ux = unit_x;
    s_uy = unit_y;
    s_us = unit_add_sub;
    s_st = unit_start;
    if (!hold) req = 4'b0000;
    // Scramble requester operands: the unit must keep seeing the latched copy.
    for (int k = 0; k < 4; k++) begin
      rx[k] = 16'($urandom);
      ry[k] = 16'($urandom);
    end
    for (int w = 0; w < budget; w++) begin
      @(posedge clk); #1;
      if (w == 0) s_g_after = grant;
      if (unit_x !== s_ux || unit_y !== s_uy || unit_add_sub !== s_us) s_stable = 1'b0;
      if (resp_valid) begin
        s_got_resp = 1'b1;
        s_id  = resp_id;
        s_res = resp_result;
        s_fl  = resp_ofuf;
        break;
      end
      s_run++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " grant"}, 32'(grant), 32'h0);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
    chk({tag, " resp_id"}, 32'(resp_id), 32'h0);
    chk({tag, " resp_result"}, 32'(resp_result), 32'h0);
    chk({tag, " resp_ofuf"}, 32'(resp_ofuf), 32'h0);
    chk({tag, " unit_x"}, 32'(unit_x), 32'h0);
    chk({tag, " unit_y"}, 32'(unit_y), 32'h0);
    chk({tag, " unit_add_sub"}, 32'(unit_add_sub), 32'h0);
    chk({tag, " unit_start"}, 32'(unit_start), 32'h0);
  endtask

  typedef struct {
    int unsigned id;
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    int          lat;
    logic [15:0] res;
    logic [1:0]  fl;
  } vec_t;

  localparam int NV = 7;
  vec_t vec[NV];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one;
    logic [3:0] exp_order[5];
    int unsigned ptr_m, k;
    logic [18:0] ef;
    time t_prev;
    int seen;

    vec[0] = '{0, 16'h3C00, 16'h4000, 1'b0, 1, 16'h4200, 2'b00};
    vec[1] = '{2, 16'h0000, 16'h4000, 1'b1, 2, 16'hC000, 2'b00};
    vec[2] = '{1, 16'h7800, 16'h7800, 1'b0, 0, 16'h0000, 2'b10};
    vec[3] = '{3, 16'h4000, 16'h3C00, 1'b1, 3, 16'h3C00, 2'b00};
    vec[4] = '{0, 16'h7BFF, 16'h7BFF, 1'b0, 1, 16'h0000, 2'b10};
    vec[5] = '{2, 16'h0401, 16'h0400, 1'b1, 0, 16'h0000, 2'b01};
    vec[6] = '{1, 16'h3C00, 16'h3C00, 1'b0, 4, 16'h4000, 2'b00};

    reset = 1'b1;
    req   = 4'b0000;
    rs    = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      rx[i] = 16'($urandom);
      ry[i] = 16'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Directed vectors, one requester at a time.
    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < 4; j++) begin
        rx[j] = 16'($urandom);
        ry[j] = 16'($urandom);
      end
      rs = 4'($urandom);
      rx[vec[i].id] = vec[i].x;
      ry[vec[i].id] = vec[i].y;
      rs[vec[i].id] = vec[i].s;
      stub_lat = vec[i].lat;
      one = 4'b0001 << vec[i].id;
      serve(one, 100, 1'b0);
      chk($sformatf("vec%0d grant", i), 32'(s_g), 32'(one));
      chk($sformatf("vec%0d start", i), 32'(s_st), 32'h1);
      chk($sformatf("vec%0d grant pulse", i), 32'(s_g_after), 32'h0);
      chk($sformatf("vec%0d unit_x", i), 32'(s_ux), 32'(vec[i].x));
      chk($sformatf("vec%0d unit_y", i), 32'(s_uy), 32'(vec[i].y));
      chk($sformatf("vec%0d addsub", i), 32'(s_us), 32'(vec[i].s));
      chk($sformatf("vec%0d resp seen", i), 32'(s_got_resp), 32'h1);
      chk($sformatf("vec%0d id", i), 32'(s_id), vec[i].id);
      chk($sformatf("vec%0d result", i), 32'(s_res), 32'(vec[i].res));
      chk($sformatf("vec%0d flags", i), 32'(s_fl), 32'(vec[i].fl));
      chk($sformatf("vec%0d run cycles", i), 32'(s_run), 32'(vec[i].lat + 2));
      chk($sformatf("vec%0d operands stable", i), 32'(s_stable), 32'h1);
    end

    // Round robin: serve 3 to bring the pointer to 0, then hold all requests.
    stub_lat = 0;
    serve(4'b1000, 100, 1'b0);
    chk("rr setup grant", 32'(s_g), 32'h8);
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      serve(4'b1111, 100, 1'b1);
      chk($sformatf("rr grant %0d", i), 32'(s_g), 32'(exp_order[i]));
      if (i > 0) chk($sformatf("rr spacing %0d", i), 32'((s_gtime - t_prev) >= 40), 32'h1);
      t_prev = s_gtime;
    end
    serve(4'b1010, 100, 1'b1);
    chk("rr 1010 first", 32'(s_g), 32'h2);
    serve(4'b1010, 100, 1'b0);
    chk("rr 1010 next", 32'(s_g), 32'h8);

    // Watchdog: the unit never answers.
    stub_silent = 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
    serve(4'b0100, 200, 1'b0);
    chk("timeout resp", 32'(s_got_resp), 32'h1);
    chk("timeout flags", 32'(s_fl), 32'h3);
    chk("timeout result", 32'(s_res), 32'h0);
    chk("timeout id", 32'(s_id), 32'h2);
    chk("timeout run cycles", 32'(s_run), TIMEOUT);
`else
    serve(4'b0100, 1000, 1'b0);
    chk("no-timeout grant", 32'(s_got_grant), 32'h1);
    chk("no-timeout no resp", 32'(s_got_resp), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    // Mid-operation reset with requester 3 in flight.
    serve(4'b1000, 5, 1'b0);
    chk("midrst grant", 32'(s_g), 32'h8);
    chk("midrst no resp yet", 32'(s_got_resp), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    reset = 1'b0;
    stub_silent = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("midrst abandoned", 32'(seen), 32'h0);
    serve(4'b1001, 100, 1'b0);
    chk("midrst ptr restart", 32'(s_g), 32'h1);
    serve(4'b1000, 100, 1'b0);
    chk("midrst req3 grant", 32'(s_g), 32'h8);
    chk("midrst req3 resp", 32'(s_got_resp), 32'h1);
    chk("midrst req3 id", 32'(s_id), 32'h3);

    // Randomized operations against the arbitration model.
    ptr_m = 0;
    for (int it = 0; it < 40; it++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4; j++) begin
        rx[j] = 16'($urandom);
        ry[j] = 16'($urandom);
      end
      rs = 4'($urandom);
      stub_lat = int'($urandom_range(0, 4));
      k = ptr_m;
      for (int off = 0; off < 4; off++) begin
        if (mask[(ptr_m + off) % 4]) begin
          k = (ptr_m + off) % 4;
          break;
        end
      end
      ef = unit_fn(rx[k], ry[k], rs[k]);
      one = 4'b0001 << k;
      serve(mask, 100, 1'b0);
      chk($sformatf("rnd%0d grant", it), 32'(s_g), 32'(one));
      chk($sformatf("rnd%0d id", it), 32'(s_id), k);
      chk($sformatf("rnd%0d flags", it), 32'(s_fl), 32'(ef[17:16]));
      chk($sformatf("rnd%0d result", it), 32'(s_res),
          (ef[17:16] != 2'b00) ? 32'h0 : 32'(ef[15:0]));
      chk($sformatf("rnd%0d run cycles", it), 32'(s_run), 32'(stub_lat + 2));
      ptr_m = (k + 1) % 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
